// File: rtl/mac_table_manage_if.sv
// Bundles the learning-write, lookup-request and lookup-result signals of the
// MAC table manager so both ends share a single port.
interface mac_table_manage_if #(
    parameter int PORT_NUM = 9
);
    logic [47+PORT_NUM:0]  iv_smac_inport;
    logic [4:0]            iv_entry_addr;
    logic                  i_mactable_wr;
    logic                  i_table_flush;
    logic [47:0]           iv_dmac;
    logic [PORT_NUM-1:0]   iv_lookup_inport;
    logic                  i_lookup_req;
    logic [PORT_NUM-1:0]   ov_outport;
    logic                  o_outport_wr;
    logic                  o_lookup_hit;
    logic [4:0]            ov_hit_addr;
    logic [5:0]            ov_valid_num;

    modport master (
        output iv_smac_inport, iv_entry_addr, i_mactable_wr, i_table_flush,
               iv_dmac, iv_lookup_inport, i_lookup_req,
        input  ov_outport, o_outport_wr, o_lookup_hit, ov_hit_addr, ov_valid_num
    );

    modport slave (
        input  iv_smac_inport, iv_entry_addr, i_mactable_wr, i_table_flush,
               iv_dmac, iv_lookup_inport, i_lookup_req,
        output ov_outport, o_outport_wr, o_lookup_hit, ov_hit_addr, ov_valid_num
    );
endinterface

// File: rtl/mac_table_manage.sv
// 32-entry learned-MAC table with timer-based aging and a two-stage DMAC
// lookup that returns a forwarding bitmap (unicast hit, filter or flood).
module mac_table_manage #(
    parameter logic [31:0] AGE_TICK = 32'd1000000,
    parameter logic [3:0]  AGE_MAX  = 4'd10,
    parameter int          PORT_NUM = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    mac_table_manage_if.slave bus
);
    localparam int N = 32;

    function automatic logic [5:0] popcount32(input logic [N-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < N; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    logic [N-1:0]        valid_r;
    logic [47:0]         mac_r  [N];
    logic [PORT_NUM-1:0] port_r [N];
    logic [3:0]          age_r  [N];
    logic [31:0]         presc_r;
    logic                tick_s;

    logic [N-1:0]        match_s;
    logic                s1_vld_r;
    logic                s1_mcast_r;
    logic [PORT_NUM-1:0] s1_inport_r;
    logic [N-1:0]        s1_match_r;

    logic                found_s;
    logic [4:0]          idx_s;
    logic                nxt_hit_s;
    logic [4:0]          nxt_addr_s;
    logic [PORT_NUM-1:0] nxt_port_s;

    assign tick_s = (presc_r == (AGE_TICK - 32'd1));

    // Aging prescaler: free-running 0..AGE_TICK-1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_r <= 32'd0;
        end else if (tick_s) begin
            presc_r <= 32'd0;
        end else begin
            presc_r <= presc_r + 32'd1;
        end
    end

    // Table update; a write to an index overrides flush and aging on it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r <= '0;
            for (int i = 0; i < N; i++) begin
                age_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.i_mactable_wr && (bus.iv_entry_addr == 5'(i))) begin
                    valid_r[i] <= 1'b1;
                    mac_r[i]   <= bus.iv_smac_inport[47+PORT_NUM:PORT_NUM];
                    port_r[i]  <= bus.iv_smac_inport[PORT_NUM-1:0];
                    age_r[i]   <= 4'd0;
                end else if (bus.i_table_flush) begin
                    valid_r[i] <= 1'b0;
                end else if (tick_s && valid_r[i]) begin
                    if (age_r[i] == AGE_MAX) begin
                        valid_r[i] <= 1'b0;
                    end else begin
                        age_r[i] <= age_r[i] + 4'd1;
                    end
                end
            end
        end
    end

    // Match vector against the table as it stands before this cycle's write
    always_comb begin
        match_s = '0;
        for (int i = 0; i < N; i++) begin
            match_s[i] = valid_r[i] && (mac_r[i] == bus.iv_dmac);
        end
    end

    // Lookup stage 1: capture request, key attributes and match vector
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_r    <= 1'b0;
            s1_mcast_r  <= 1'b0;
            s1_inport_r <= '0;
            s1_match_r  <= '0;
        end else begin
            s1_vld_r    <= bus.i_lookup_req;
            s1_mcast_r  <= bus.iv_dmac[40];
            s1_inport_r <= bus.iv_lookup_inport;
            s1_match_r  <= match_s;
        end
    end

    // Lowest-index priority encoder; scanning downward leaves the lowest hit
    always_comb begin
        found_s = 1'b0;
        idx_s   = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            found_s = found_s | s1_match_r[i];
            idx_s   = s1_match_r[i] ? 5'(i) : idx_s;
        end
    end

    // Result selection: multicast always floods, matching ingress port filters
    always_comb begin
        nxt_hit_s  = 1'b0;
        nxt_addr_s = 5'd0;
        nxt_port_s = ~s1_inport_r;
        if (found_s && !s1_mcast_r) begin
            nxt_hit_s  = 1'b1;
            nxt_addr_s = idx_s;
            nxt_port_s = (port_r[idx_s] == s1_inport_r) ? '0 : port_r[idx_s];
        end else begin
            nxt_hit_s  = 1'b0;
            nxt_addr_s = 5'd0;
            nxt_port_s = ~s1_inport_r;
        end
    end

    // Lookup stage 2: registered results, held between result pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_outport_wr <= 1'b0;
            bus.o_lookup_hit <= 1'b0;
            bus.ov_hit_addr  <= 5'd0;
            bus.ov_outport   <= '0;
        end else begin
            bus.o_outport_wr <= s1_vld_r;
            if (s1_vld_r) begin
                bus.o_lookup_hit <= nxt_hit_s;
                bus.ov_hit_addr  <= nxt_addr_s;
                bus.ov_outport   <= nxt_port_s;
            end
        end
    end

    // Occupancy count, one cycle behind the valid bits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.ov_valid_num <= 6'd0;
        end else begin
            bus.ov_valid_num <= popcount32(valid_r);
        end
    end
endmodule

// File: doc/mac_table_manage.md
Name: mac_table_manage

Overview:
Downstream consumer of the MAC self-learning stage. Stores the learned {SMAC, inport} entries in a 32-entry table, using the write strobe and entry address that stage produces. Serves a pipelined DMAC lookup for the forwarding path and returns an output-port bitmap. Ages out stale entries with a periodic timer.

Parameters:
AGE_TICK, 32'd1000000, clock cycles per aging tick (range 2..2^32-1)
AGE_MAX, 4'd10, number of ticks without refresh before an entry is invalidated (range 1..15)
PORT_NUM, 9, width of port bitmap

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
iv_smac_inport  in  57  learned entry: [56:9]=SMAC, [8:0]=inport bitmap
iv_entry_addr  in  5  table index to write
i_mactable_wr  in  1  write strobe, one-cycle pulse
i_table_flush  in  1  clear all valid bits
iv_dmac  in  48  lookup key
iv_lookup_inport  in  9  ingress port of the looked-up frame (flood mask)
i_lookup_req  in  1  lookup strobe; one accepted every cycle
ov_outport  out  9  forwarding bitmap
o_outport_wr  out  1  result valid, one-cycle pulse
o_lookup_hit  out  1  1 = unicast hit, 0 = flood
ov_hit_addr  out  5  matching entry index (0 on flood)
ov_valid_num  out  6  count of valid entries, 0..32

Behaviour:
- Reset (i_rst sampled high at a clock edge):
  - All valid bits, ages and the prescaler are cleared.
  - All outputs go to 0.
  - Any lookup in flight is discarded; no o_outport_wr is issued for it.
- Table entry: valid(1), mac(48), port(9), age(4).
- Write: on i_mactable_wr, entry[iv_entry_addr] gets mac=[56:9], port=[8:0], valid=1, age=0.
  - A write to an already-valid index overwrites it.
- Flush: i_table_flush clears all valid bits.
  - Flush and write in the same cycle: write wins for its index; all other entries are cleared.
- Aging:
  - Prescaler counts 0..AGE_TICK-1; tick is asserted when the count equals AGE_TICK-1, then the count wraps to 0.
  - On a tick, each valid entry with age==AGE_MAX is invalidated; every other valid entry does age+1.
  - Invalid entries are untouched.
  - Write and tick on the same index in the same cycle: write wins (valid=1, age=0).
- Lookup pipeline, latency 2:
  - Cycle N (req high): register iv_dmac and iv_lookup_inport, plus the 32-bit match vector: bit i = valid_i && mac_i==iv_dmac, using table contents before any same-cycle write.
  - Cycle N+1: priority encode (lowest index wins) and register the outputs.
  - Cycle N+2: o_outport_wr=1 with valid results.
  - Back-to-back requests give back-to-back results, in order.
- Result rules:
  - Multicast/broadcast DMAC (iv_dmac[40]==1): flood, even if an entry matches.
  - Flood: hit=0, addr=0, outport = 9'h1FF & ~iv_lookup_inport.
  - Unicast hit: hit=1, addr=index, outport = entry port.
  - Hit whose port equals iv_lookup_inport: outport=0 (filter, frame dropped), hit=1.
- ov_outport, o_lookup_hit and ov_hit_addr hold their last value when o_outport_wr=0.
- ov_valid_num: registered popcount of the valid bits; reflects a table change one cycle after it.

Test Plan:
- Write: addr 3, SMAC 48'h0011_2233_4455, port 9'h004. Lookup that DMAC, inport 9'h001, 2 cycles later -> o_outport_wr=1, hit=1, addr=3, outport 9'h004, valid_num=1.
- Miss: lookup 48'h00AA_BBCC_DDEE, inport 9'h010 -> hit=0, outport 9'h1EF. Multicast DMAC 48'h0100_5E00_0001 that also matches entry 5 -> flood, hit=0.
- Same MAC written at addr 7 and addr 2 -> lookup returns addr 2. Write addr 3 in the same cycle as a lookup of its new MAC -> miss; next request -> hit.
- AGE_TICK=4, AGE_MAX=2, write entry 0 -> still hit after 2 ticks; miss after the 3rd tick; valid_num goes 1->0. Rewrite coinciding with the expiring tick -> entry stays valid, age=0.
- Issue 3 consecutive lookups -> 3 consecutive o_outport_wr pulses in order. Assert i_rst in the cycle after the 2nd request -> no further pulses; all outputs 0; valid_num=0.
- Fill all 32 entries -> valid_num=32. Flush with a concurrent write to addr 9 -> valid_num=1, only entry 9 hits.
